mem2axi_reader: RTL and testbench

- Read-side counterpart of the AXI-to-memory packer.
- Pops 202-bit packed memory words from a first-word-fall-through queue on the memory side and rebuilds an AXI4-Stream master: 256-bit tdata, 32-bit tstrb, 128-bit tuser, tlast.
- Sits between the per-queue SRAM read path and the output port.
- Contains a 192-to-256-bit gearbox, a header/packet state machine and word-format checks.

---
 rtl/mem_word_pkg.sv | 33 +++
 rtl/word_gearbox_192to256.sv | 65 ++++++
 rtl/mem2axi_reader.sv | 166 ++++++++++++++++
 tb/tb_mem2axi_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_word_pkg.sv
// Field layout, word-type codes and FSM states shared by the memory-word
// packer/reader pair.
package mem_word_pkg;

   localparam int unsigned PAY_MSB  = 201;
   localparam int unsigned PAY_LSB  = 10;
   localparam int unsigned CNT_MSB  = 9;
   localparam int unsigned CNT_LSB  = 5;
   localparam int unsigned TYPE_MSB = 4;
   localparam int unsigned TYPE_LSB = 2;
   localparam int unsigned LAST_BIT = 1;

   localparam int unsigned WORD_PAYLOAD_BYTES = 24;
   localparam int unsigned ACC_W              = 448;

   typedef enum logic [2:0] {
      WT_HDR = 3'd0,
      WT_D1  = 3'd1,
      WT_D2  = 3'd2,
      WT_D3  = 3'd3,
      WT_D4  = 3'd4
   } word_type_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   function automatic word_type_e next_phase(input word_type_e p);
      return (p == WT_D4) ? WT_D1 : word_type_e'(p + 3'd1);
   endfunction

endpackage

// File: rtl/word_gearbox_192to256.sv
// Byte accumulator that appends up to 24 payload bytes per push and drains
// 32-byte beats from the bottom.
module word_gearbox_192to256
   import mem_word_pkg::*;
(
   input  logic         clk,
   input  logic         resetn,
   input  logic         push_i,
   input  logic [191:0] push_data_i,
   input  logic [4:0]   push_bytes_i,
   input  logic         shift_i,
   output logic [5:0]   acc_bytes_o,
   output logic [255:0] beat_data_o,
   output logic [31:0]  beat_strb_o
);

   logic [ACC_W-1:0] acc_q, acc_d, acc_s;
   logic [5:0]       bytes_q, bytes_d, bytes_s;
   logic [191:0]     pay_m;

   // Bytes above the count are zeroed so the accumulator stays clean above acc_bytes
   always_comb begin
      pay_m = '0;
      for (int unsigned i = 0; i < WORD_PAYLOAD_BYTES; i++) begin
         if (i < 32'(push_bytes_i)) pay_m[i*8 +: 8] = push_data_i[i*8 +: 8];
      end
   end

   // The shift happens first so a same-cycle push lands after the drained beat
   always_comb begin
      acc_s   = acc_q;
      bytes_s = bytes_q;
      if (shift_i) begin
         acc_s   = acc_q >> 256;
         bytes_s = (bytes_q >= 6'd32) ? bytes_q - 6'd32 : '0;
      end
      acc_d   = acc_s;
      bytes_d = bytes_s;
      if (push_i) begin
         acc_d   = acc_s | (ACC_W'(pay_m) << {bytes_s, 3'b000});
         bytes_d = bytes_s + {1'b0, push_bytes_i};
      end
   end

   always_comb begin
      beat_strb_o = '1;
      if (bytes_q < 6'd32) begin
         for (int unsigned i = 0; i < 32; i++) beat_strb_o[i] = (i < 32'(bytes_q));
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_q   <= '0;
         bytes_q <= '0;
      end else begin
         acc_q   <= acc_d;
         bytes_q <= bytes_d;
      end
   end

   assign acc_bytes_o = bytes_q;
   assign beat_data_o = acc_q[255:0];

endmodule

// File: rtl/mem2axi_reader.sv
// Rebuilds an AXI4-Stream packet from packed 202-bit memory words popped
// from a first-word-fall-through queue.
module mem2axi_reader
   import mem_word_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 256,
   parameter int unsigned USER_WIDTH    = 128,
   parameter int unsigned WORD_WIDTH    = 202,
   parameter int unsigned PAYLOAD_BYTES = 24
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [WORD_WIDTH-1:0]   din,
   input  logic                    din_valid,
   output logic                    din_rd,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic [USER_WIDTH-1:0]   m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    fmt_err
);

   localparam logic [4:0] CNT_MAX = 5'(PAYLOAD_BYTES);

   state_e                  state_q, state_d;
   word_type_e              phase_q, phase_d;
   logic                    last_seen_q, last_seen_d;
   logic [USER_WIDTH-1:0]   hdr_user_q, hdr_user_d;
   logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
   logic [DATA_WIDTH/8-1:0] tstrb_q, tstrb_d;
   logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
   logic                    tlast_q, tlast_d;
   logic                    tvalid_q, tvalid_d;
   logic                    fmt_err_q, fmt_err_d;

   logic [4:0]   w_cnt;
   logic [2:0]   w_type;
   logic         w_last, w_is_hdr;
   logic         pop, load, load_last, pkt_end;
   logic         gb_push;
   logic [4:0]   gb_bytes;
   logic [5:0]   gb_acc_bytes;
   logic [255:0] gb_data;
   logic [31:0]  gb_strb;
   logic         unused_rsvd;

   assign w_cnt       = din[CNT_MSB:CNT_LSB];
   assign w_type      = din[TYPE_MSB:TYPE_LSB];
   assign w_last      = din[LAST_BIT];
   assign w_is_hdr    = (w_type == WT_HDR);
   assign unused_rsvd = din[0];

   word_gearbox_192to256 u_gearbox (
      .clk          (clk),
      .resetn       (resetn),
      .push_i       (gb_push),
      .push_data_i  (din[PAY_MSB:PAY_LSB]),
      .push_bytes_i (gb_bytes),
      .shift_i      (load),
      .acc_bytes_o  (gb_acc_bytes),
      .beat_data_o  (gb_data),
      .beat_strb_o  (gb_strb)
   );

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      last_seen_d = last_seen_q;
      hdr_user_d  = hdr_user_q;
      tdata_d     = tdata_q;
      tstrb_d     = tstrb_q;
      tuser_d     = tuser_q;
      tlast_d     = tlast_q;
      tvalid_d    = tvalid_q && !m_axis_tready;
      fmt_err_d   = 1'b0;
      pop         = 1'b0;
      gb_push     = 1'b0;
      gb_bytes    = CNT_MAX;

      load      = (!tvalid_q || m_axis_tready) &&
                  ((gb_acc_bytes >= 6'd32) || (last_seen_q && gb_acc_bytes != '0));
      load_last = load && last_seen_q && (gb_acc_bytes <= 6'd32);
      // An aborted packet with nothing buffered closes without a beat
      pkt_end   = (state_q == ST_DATA) &&
                  (load_last || (last_seen_q && gb_acc_bytes == '0));

      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = gb_data;
         tstrb_d  = gb_strb;
         tuser_d  = hdr_user_q;
         tlast_d  = load_last;
      end

      // Packet end behaves like IDLE so the next header pops in the same cycle
      if (state_q == ST_IDLE || pkt_end) begin
         if (pkt_end) begin
            state_d     = ST_IDLE;
            last_seen_d = 1'b0;
            phase_d     = WT_D1;
         end
         if (din_valid) begin
            pop = 1'b1;
            if (w_is_hdr && !w_last) begin
               hdr_user_d  = din[PAY_LSB +: USER_WIDTH];
               state_d     = ST_DATA;
               last_seen_d = 1'b0;
               phase_d     = WT_D1;
            end else begin
               fmt_err_d = 1'b1;
            end
         end
      end else if (din_valid && !last_seen_q) begin
         if (w_is_hdr) begin
            fmt_err_d   = 1'b1;
            last_seen_d = 1'b1;
         end else if (gb_acc_bytes < 6'd32) begin
            pop     = 1'b1;
            gb_push = 1'b1;
            if (w_type != phase_q) fmt_err_d = 1'b1;
            if (w_cnt == '0 || w_cnt > CNT_MAX) fmt_err_d = 1'b1;
            if (!w_last && w_cnt != CNT_MAX) fmt_err_d = 1'b1;
            gb_bytes    = !w_last ? CNT_MAX : ((w_cnt > CNT_MAX) ? CNT_MAX : w_cnt);
            phase_d     = next_phase(phase_q);
            last_seen_d = w_last;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         phase_q     <= WT_D1;
         last_seen_q <= 1'b0;
         hdr_user_q  <= '0;
         tdata_q     <= '0;
         tstrb_q     <= '0;
         tuser_q     <= '0;
         tlast_q     <= 1'b0;
         tvalid_q    <= 1'b0;
         fmt_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         last_seen_q <= last_seen_d;
         hdr_user_q  <= hdr_user_d;
         tdata_q     <= tdata_d;
         tstrb_q     <= tstrb_d;
         tuser_q     <= tuser_d;
         tlast_q     <= tlast_d;
         tvalid_q    <= tvalid_d;
         fmt_err_q   <= fmt_err_d;
      end
   end

   assign din_rd        = pop && resetn;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tstrb  = tstrb_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign fmt_err       = fmt_err_q;

endmodule

// File: tb/tb_mem2axi_reader.sv
// Directed bench for mem2axi_reader: a FWFT source queue feeds the DUT and a
// scoreboard of expected beats is compared on every accepted output beat.
module tb_mem2axi_reader;

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  s;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [201:0] din = '0;
   logic         din_valid = 1'b0;
   logic         din_rd;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tstrb;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b1;
   logic         fmt_err;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int fmt_cnt = 0;
   int beats_seen = 0;
   int b0;

   logic [201:0] src[$];
   beat_t        sb[$];
   int           hdr_cyc[$];
   int           tlast_cyc[$];
   bit           do_pop = 1'b0;
   bit           prev_stall = 1'b0;
   beat_t        prev_beat, cur_beat, exp_beat;

   always #5 clk = ~clk;

   mem2axi_reader #(
      .DATA_WIDTH    (256),
      .USER_WIDTH    (128),
      .WORD_WIDTH    (202),
      .PAYLOAD_BYTES (24)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .din           (din),
      .din_valid     (din_valid),
      .din_rd        (din_rd),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .fmt_err       (fmt_err)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [201:0] mk_word(input logic [191:0] pay, input logic [4:0] cnt,
                                            input logic [2:0] typ, input logic last);
      return {pay, cnt, typ, last, 1'b0};
   endfunction

   // Header plus n data words; expected beats come from the flat byte stream
   task automatic send_pkt(input int pid, input logic [127:0] user, input int n,
                           input logic [19:0] cnts, input logic [11:0] types,
                           input bit expect_out, input bit close);
      logic [7:0]   bytes[$];
      logic [191:0] pay;
      logic [4:0]   c;
      int           idx = 0;
      beat_t        b;
      src.push_back(mk_word({64'b0, user}, 5'd0, 3'd0, 1'b0));
      for (int k = 0; k < n; k++) begin
         c   = cnts[k*5 +: 5];
         pay = {24{8'hC3}};
         for (int i = 0; i < int'(c); i++) begin
            pay[i*8 +: 8] = 8'(pid*37 + idx);
            bytes.push_back(8'(pid*37 + idx));
            idx++;
         end
         src.push_back(mk_word(pay, c, types[k*3 +: 3], close && (k == n-1)));
      end
      if (expect_out) begin
         while (bytes.size() > 0) begin
            b   = '0;
            b.u = user;
            for (int i = 0; i < 32 && bytes.size() > 0; i++) begin
               b.d[i*8 +: 8] = bytes.pop_front();
               b.s[i] = 1'b1;
            end
            b.l = (bytes.size() == 0);
            sb.push_back(b);
         end
      end
   endtask

   task automatic drain(input bit toggle, input int budget);
      int         cyc = 0;
      logic [3:0] pat = 4'b1001;
      while ((src.size() != 0 || sb.size() != 0) && cyc < budget) begin
         @(posedge clk); #1;
         m_axis_tready = toggle ? pat[cyc % 4] : 1'b1;
         cyc++;
      end
      chk("drain_in_budget", 256'(cyc < budget), 256'd1);
      m_axis_tready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_src(input int budget);
      int cyc = 0;
      while (src.size() != 0 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("src_in_budget", 256'(cyc < budget), 256'd1);
   endtask

   // FWFT source: pop decided from din_rd sampled at the falling edge
   always @(posedge clk) begin
      #1;
      if (do_pop && src.size() != 0) void'(src.pop_front());
      #1;
      din_valid = (src.size() != 0);
      if (din_valid) din = src[0];
      else din = '0;
   end

   always @(negedge clk) begin
      cycle++;
      do_pop = din_rd && din_valid;
      if (do_pop && din[4:2] == 3'd0 && !din[1]) hdr_cyc.push_back(cycle);
      if (fmt_err) fmt_cnt++;
      cur_beat.d = m_axis_tdata;
      cur_beat.s = m_axis_tstrb;
      cur_beat.u = m_axis_tuser;
      cur_beat.l = m_axis_tlast;
      if (!resetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_tvalid", 256'(m_axis_tvalid), 256'd1);
            chk("hold_tdata", cur_beat.d, prev_beat.d);
            chk("hold_tstrb_tuser_tlast", {95'b0, cur_beat.s, cur_beat.u, cur_beat.l},
                {95'b0, prev_beat.s, prev_beat.u, prev_beat.l});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            beats_seen++;
            if (m_axis_tlast) tlast_cyc.push_back(cycle);
            chk("beat_expected", 256'(sb.size() != 0), 256'd1);
            if (sb.size() != 0) begin
               exp_beat = sb.pop_front();
               chk("tdata", cur_beat.d, exp_beat.d);
               chk("tstrb", 256'(cur_beat.s), 256'(exp_beat.s));
               chk("tuser", 256'(cur_beat.u), 256'(exp_beat.u));
               chk("tlast", 256'(cur_beat.l), 256'(exp_beat.l));
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = cur_beat;
      end
   end

   initial begin
      resetn        = 1'b0;
      m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      chk("rst_ctl", {253'b0, m_axis_tlast, fmt_err, din_rd}, 256'd0);
      chk("rst_tdata", m_axis_tdata, 256'd0);
      chk("rst_tstrb_tuser", {96'b0, m_axis_tstrb, m_axis_tuser}, 256'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Full 3-beat packet
      fmt_cnt = 0; b0 = beats_seen;
      send_pkt(1, {96'b0, 8'hAF, 24'h1}, 4, {5'd24, 5'd24, 5'd24, 5'd24},
               {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
      drain(1'b0, 200);
      chk("t1_beats", 256'(beats_seen - b0), 256'd3);
      chk("t1_fmt", 256'(fmt_cnt), 256'd0);

      // 40-byte packet with a short last word
      fmt_cnt = 0; b0 = beats_seen;
      send_pkt(2, {96'b0, 8'hB2, 24'h7}, 2, {10'b0, 5'd16, 5'd24},
               {6'b0, 3'd2, 3'd1}, 1'b1, 1'b1);
      drain(1'b0, 200);
      chk("t2_beats", 256'(beats_seen - b0), 256'd2);
      chk("t2_fmt", 256'(fmt_cnt), 256'd0);

      // Backpressure pattern 1,0,0,1
      fmt_cnt = 0; b0 = beats_seen;
      send_pkt(3, {96'b0, 8'hAF, 24'h1}, 4, {5'd24, 5'd24, 5'd24, 5'd24},
               {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
      drain(1'b1, 300);
      chk("t3_beats", 256'(beats_seen - b0), 256'd3);
      chk("t3_fmt", 256'(fmt_cnt), 256'd0);

      // Phase mismatch D1 then D3: one error pulse, data still delivered
      fmt_cnt = 0; b0 = beats_seen;
      send_pkt(4, {96'b0, 8'h44, 24'h3}, 2, {10'b0, 5'd24, 5'd24},
               {6'b0, 3'd3, 3'd1}, 1'b1, 1'b1);
      drain(1'b0, 200);
      chk("t4_fmt", 256'(fmt_cnt), 256'd1);
      chk("t4_beats", 256'(beats_seen - b0), 256'd2);

      // Data word while idle is dropped
      fmt_cnt = 0; b0 = beats_seen;
      src.push_back(mk_word({24{8'h11}}, 5'd24, 3'd1, 1'b1));
      drain(1'b0, 50);
      chk("t4_idle_fmt", 256'(fmt_cnt), 256'd1);
      chk("t4_idle_beats", 256'(beats_seen - b0), 256'd0);

      // Reset mid-packet with the first beat held under backpressure
      fmt_cnt = 0;
      m_axis_tready = 1'b0;
      send_pkt(5, {96'b0, 8'h55, 24'h5}, 2, {10'b0, 5'd24, 5'd24},
               {6'b0, 3'd2, 3'd1}, 1'b0, 1'b0);
      wait_src(50);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_held_tvalid", 256'(m_axis_tvalid), 256'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      m_axis_tready = 1'b1;
      @(negedge clk);
      chk("t5_rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      chk("t5_rst_ctl", {254'b0, m_axis_tlast, fmt_err}, 256'd0);
      chk("t5_rst_tdata", m_axis_tdata, 256'd0);
      chk("t5_rst_tstrb_tuser", {96'b0, m_axis_tstrb, m_axis_tuser}, 256'd0);
      @(posedge clk); #1;
      b0 = beats_seen;
      send_pkt(6, {96'b0, 8'hEA, 24'h2}, 4, {5'd24, 5'd24, 5'd24, 5'd24},
               {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
      drain(1'b0, 200);
      chk("t5_beats", 256'(beats_seen - b0), 256'd3);
      chk("t5_fmt", 256'(fmt_cnt), 256'd0);

      // Back-to-back packets: next header pops as the tlast beat loads
      fmt_cnt = 0; b0 = beats_seen;
      hdr_cyc.delete();
      tlast_cyc.delete();
      send_pkt(7, {96'b0, 8'h77, 24'h7}, 4, {5'd24, 5'd24, 5'd24, 5'd24},
               {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
      send_pkt(8, {96'b0, 8'h88, 24'h8}, 4, {5'd24, 5'd24, 5'd24, 5'd24},
               {3'd4, 3'd3, 3'd2, 3'd1}, 1'b1, 1'b1);
      drain(1'b0, 300);
      chk("t6_beats", 256'(beats_seen - b0), 256'd6);
      chk("t6_fmt", 256'(fmt_cnt), 256'd0);
      chk("t6_hdr_pops", 256'(hdr_cyc.size()), 256'd2);
      chk("t6_tlasts", 256'(tlast_cyc.size()), 256'd2);
      if (hdr_cyc.size() >= 2 && tlast_cyc.size() >= 2) begin
         chk("t6_hdr2_with_tlast", 256'(tlast_cyc[0] - hdr_cyc[1]), 256'd1);
         chk("t6_pkt_period", 256'(tlast_cyc[1] - tlast_cyc[0]), 256'd7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
